flex_pkt_fifo: RTL and testbench
================================

# flex_pkt_fifo

Parametrised packet FIFO with commit/discard semantics for the USB-to-AES data path. The receive side writes packet bytes tentatively and then commits them (good CRC) or discards them (bad CRC/abort); the read side sees only committed bytes. Unlike a plain FIFO, all DEPTH entries are usable, and the block reports occupancy and in-flight packet length.

## Interface
- NUMBITS, 8, data word width
- DEPTH, 64, entry count; power of 2, ≥ 2
- ADDR, $clog2(DEPTH), derived localparam; pointers are ADDR+1 bits wide (the extra bit is the wrap bit)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- w_enable  in  1  write request
- w_data  in  NUMBITS  write data
- w_commit  in  1  make all tentative data, including any write accepted this cycle, visible to the reader
- w_discard  in  1  drop all tentative data, including any write requested this cycle
- r_enable  in  1  pop request
- r_data  out  NUMBITS  committed head word, first-word fall-through
- empty  out  1  no committed data
- full  out  1  no free entry (tentative plus committed data equals DEPTH)
- count  out  ADDR+1  committed occupancy, 0..DEPTH
- pkt_len  out  ADDR+1  tentative (uncommitted) word count, 0..DEPTH
- err_clr  in  1  clears sticky errors (only with FLEX_PKT_FIFO_ERR_EN)
- overflow  out  1  sticky: write attempted while full (only with FLEX_PKT_FIFO_ERR_EN)
- underflow  out  1  sticky: read attempted while empty (only with FLEX_PKT_FIFO_ERR_EN)

## Operation
- Pointers: wr_ptr (tentative tail), cmt_ptr (committed tail), rd_ptr (head). Each is ADDR+1 bits, incremented mod 2^(ADDR+1).
- Memory is indexed by the low ADDR bits of each pointer.
- Write accepted when w_enable && !full && !w_discard: mem[wr_ptr] <= w_data and wr_ptr increments.
- Read accepted when r_enable && !empty: rd_ptr increments.
- Commit when w_commit && !w_discard: cmt_ptr <= next wr_ptr, so a write accepted in the same cycle is committed.
- Discard when w_discard: wr_ptr <= cmt_ptr. A same-cycle write is dropped and memory is unchanged. If w_commit is also asserted, discard wins.
- All flags and counts are combinational from the registered pointers:
  - empty = (rd_ptr == cmt_ptr)
  - full = ((wr_ptr - rd_ptr) == DEPTH)
  - count = cmt_ptr - rd_ptr
  - pkt_len = wr_ptr - cmt_ptr
- Simultaneous read and write are both evaluated against current-cycle flags.
  - When full, a read in the same cycle does not unblock the write.
  - When empty, a same-cycle write plus commit does not allow the read.
- A read never crosses cmt_ptr. Tentative data is unreachable by the reader.
- Wrap-around: the wrap bit distinguishes full from empty. Pointers roll over from 2^(ADDR+1)-1 to 0 with no special case.

## Timing
- Reset values:
  - all pointers 0; memory 0
  - r_data 0, empty 1, full 0, count 0, pkt_len 0
  - overflow 0, underflow 0
- Reset asserted mid-packet or mid-read aborts everything immediately. No data survives.
- Write-to-read latency: a word written and committed in cycle N appears on r_data and clears empty after edge N+1.
- A commit issued in a cycle later than the writes takes effect at that cycle's edge.
- r_data changes combinationally with rd_ptr. It updates after the same edge that pops the previous word.
- full and count reflect accepted operations one edge later. No output depends combinationally on a request input.

## Configuration
- FLEX_PKT_FIFO_ERR_EN defined:
  - Ports err_clr, overflow and underflow exist.
  - overflow sets on w_enable && full && !w_discard.
  - underflow sets on r_enable && empty.
  - Both flags hold until err_clr. If err_clr and a set condition occur in the same cycle, set wins.
- FLEX_PKT_FIFO_ERR_EN undefined:
  - The three ports are absent.
  - Illegal requests are silently ignored, with identical data behaviour.

## Structure
- Package flex_fifo_pkg holds:
  - default NUMBITS and DEPTH constants
  - a function ptr_diff(a, b) returning the ADDR+1-bit modular difference, used for count, pkt_len and full
- Sub-module flex_fifo_ptr: ADDR+1-bit pointer register with asynchronous active-high reset, inc and load/load_val inputs (load has priority).
  - Three instances: wr_ptr (load = discard), cmt_ptr (load = commit), rd_ptr (no load).

## Test plan
- Reset, then write 3 words (0xA1, 0xA2, 0xA3) without commit.
  - Required: empty = 1, pkt_len = 3, count = 0.
  - Then assert w_commit alone: next cycle empty = 0, count = 3, r_data = 0xA1.
- Write 2 words, then w_discard with a same-cycle write of 0xFF.
  - Required: pkt_len = 0, count unchanged, and 0xFF never appears on r_data.
- DEPTH = 4: write and commit 4 words.
  - Required: full = 1, count = 4.
  - A further write is ignored (overflow = 1 with the macro). Reading all 4 returns them in order, then empty = 1.
- Continuous stream of 10 × DEPTH words with commit every 3 words and simultaneous reads.
  - Required: output order matches input order across pointer wrap, with no loss.
- Same cycle w_enable (0x55) + w_commit on an empty FIFO, plus r_enable.
  - Required: no pop this cycle; next cycle r_data = 0x55, count = 1.
- Assert rst mid-packet with count = 2 and pkt_len = 1.
  - Required: all outputs return to reset values immediately.
  - A new write/commit afterwards reads back correctly.

Source files
------------

// File: rtl/flex_fifo_pkg.sv
// rtl/flex_fifo_pkg.sv - shared constants and pointer arithmetic for the packet FIFO
package flex_fifo_pkg;

  localparam int unsigned FLEX_FIFO_NUMBITS = 8;
  localparam int unsigned FLEX_FIFO_DEPTH   = 64;

  // Modular difference a - b truncated to 'width' bits; pointers carry a wrap bit,
  // so this yields occupancy directly even across roll-over.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/flex_fifo_ptr.sv
// rtl/flex_fifo_ptr.sv - wrap-bit pointer register with increment and priority load
module flex_fifo_ptr
  import flex_fifo_pkg::*;
#(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  // Load beats increment so a discard/commit lands exactly on its target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/flex_pkt_fifo.sv
// rtl/flex_pkt_fifo.sv - packet FIFO with commit/discard; FLEX_PKT_FIFO_ERR_EN adds sticky error flags
module flex_pkt_fifo
  import flex_fifo_pkg::*;
#(
  parameter int unsigned NUMBITS = FLEX_FIFO_NUMBITS,
  parameter int unsigned DEPTH   = FLEX_FIFO_DEPTH,
  localparam int unsigned ADDR   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_enable,
  input  logic [NUMBITS-1:0] w_data,
  input  logic               w_commit,
  input  logic               w_discard,
  input  logic               r_enable,
  output logic [NUMBITS-1:0] r_data,
  output logic               empty,
  output logic               full,
  output logic [ADDR:0]      count,
  output logic [ADDR:0]      pkt_len
`ifdef FLEX_PKT_FIFO_ERR_EN
  ,
  input  logic               err_clr,
  output logic               overflow,
  output logic               underflow
`endif
);

  localparam int unsigned PTR_W = ADDR + 1;

  logic [ADDR:0]        wr_ptr;
  logic [ADDR:0]        cmt_ptr;
  logic [ADDR:0]        rd_ptr;
  logic [ADDR:0]        wr_ptr_nxt;
  logic                 wr_accept;
  logic                 rd_accept;
  logic                 do_commit;
  logic [NUMBITS-1:0]   mem [DEPTH];

  // Request qualification uses only current-cycle flags, so a same-cycle read
  // never frees space for a write and a same-cycle commit never feeds a read.
  assign wr_accept  = w_enable && !full && !w_discard;
  assign rd_accept  = r_enable && !empty;
  assign do_commit  = w_commit && !w_discard;
  assign wr_ptr_nxt = wr_accept ? (wr_ptr + PTR_W'(1)) : wr_ptr;

  flex_fifo_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (wr_accept),
    .load     (w_discard),
    .load_val (cmt_ptr),
    .ptr      (wr_ptr)
  );

  flex_fifo_ptr #(.W(PTR_W)) u_cmt_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (1'b0),
    .load     (do_commit),
    .load_val (wr_ptr_nxt),
    .ptr      (cmt_ptr)
  );

  flex_fifo_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (rd_accept),
    .load     (1'b0),
    .load_val ({PTR_W{1'b0}}),
    .ptr      (rd_ptr)
  );

  // Storage is cleared on reset so no stale packet data survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_accept) begin
      mem[wr_ptr[ADDR-1:0]] <= w_data;
    end
  end

  assign r_data  = mem[rd_ptr[ADDR-1:0]];
  assign empty   = (rd_ptr == cmt_ptr);
  assign full    = (PTR_W'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PTR_W)) == PTR_W'(DEPTH));
  assign count   = PTR_W'(ptr_diff(32'(cmt_ptr), 32'(rd_ptr), PTR_W));
  assign pkt_len = PTR_W'(ptr_diff(32'(wr_ptr), 32'(cmt_ptr), PTR_W));

`ifdef FLEX_PKT_FIFO_ERR_EN
  logic ov_set;
  logic un_set;

  assign ov_set = w_enable && full && !w_discard;
  assign un_set = r_enable && empty;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ov_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (un_set) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_flex_pkt_fifo.sv
// tb/tb_flex_pkt_fifo.sv - randomized self-checking bench against a queue model of the packet FIFO
module tb_flex_pkt_fifo;

  localparam int NB = 8;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_enable;
  logic [NB-1:0] w_data;
  logic          w_commit;
  logic          w_discard;
  logic          r_enable;
  logic [NB-1:0] r_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic [AW:0]   pkt_len;
`ifdef FLEX_PKT_FIFO_ERR_EN
  logic          err_clr;
  logic          overflow;
  logic          underflow;
  logic          m_ov;
  logic          m_un;
`endif

  int checks = 0;
  int errors = 0;

  // Model: committed words visible to the reader, tentative words of the open packet.
  logic [NB-1:0] m_cmt[$];
  logic [NB-1:0] m_tnt[$];

  always #5 clk = ~clk;

  flex_pkt_fifo #(.NUMBITS(NB), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_enable  (w_enable),
    .w_data    (w_data),
    .w_commit  (w_commit),
    .w_discard (w_discard),
    .r_enable  (r_enable),
    .r_data    (r_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .pkt_len   (pkt_len)
`ifdef FLEX_PKT_FIFO_ERR_EN
    ,
    .err_clr   (err_clr),
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  task automatic model_reset();
    m_cmt.delete();
    m_tnt.delete();
`ifdef FLEX_PKT_FIFO_ERR_EN
    m_ov = 1'b0;
    m_un = 1'b0;
`endif
  endtask

  // One clock of stimulus; model applies the packet rules using pre-edge state.
  task automatic cycle(input logic we, input logic [NB-1:0] wd, input logic wc,
                       input logic wdis, input logic re, input logic ec);
    bit mf;
    bit me;
    w_enable  = we;
    w_data    = wd;
    w_commit  = wc;
    w_discard = wdis;
    r_enable  = re;
`ifdef FLEX_PKT_FIFO_ERR_EN
    err_clr   = ec;
`endif
    mf = (m_cmt.size() + m_tnt.size()) == DP;
    me = (m_cmt.size() == 0);
    @(posedge clk);
`ifdef FLEX_PKT_FIFO_ERR_EN
    if (we && mf && !wdis) m_ov = 1'b1; else if (ec) m_ov = 1'b0;
    if (re && me) m_un = 1'b1; else if (ec) m_un = 1'b0;
`endif
    if (re && !me) void'(m_cmt.pop_front());
    if (we && !mf && !wdis) m_tnt.push_back(wd);
    if (wdis) m_tnt.delete();
    else if (wc) while (m_tnt.size() > 0) m_cmt.push_back(m_tnt.pop_front());
    #1;
    w_enable  = 1'b0;
    w_commit  = 1'b0;
    w_discard = 1'b0;
    r_enable  = 1'b0;
`ifdef FLEX_PKT_FIFO_ERR_EN
    err_clr   = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_enable = 0; w_data = '0; w_commit = 0; w_discard = 0; r_enable = 0;
`ifdef FLEX_PKT_FIFO_ERR_EN
    err_clr = 0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (pkt_len !== 3'd0) begin errors++; $display("FAIL reset_pkt_len got %0d exp 0", pkt_len); end
    checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", r_data); end
`ifdef FLEX_PKT_FIFO_ERR_EN
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
`endif
  endtask

  task automatic test_commit();
    cycle(1, 8'hA1, 0, 0, 0, 0);
    cycle(1, 8'hA2, 0, 0, 0, 0);
    cycle(1, 8'hA3, 0, 0, 0, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL tent_empty got %b exp 1", empty); end
    checks++; if (pkt_len !== 3'd3) begin errors++; $display("FAIL tent_pkt_len got %0d exp 3", pkt_len); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL tent_count got %0d exp 0", count); end
    cycle(0, 8'h00, 1, 0, 0, 0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL cmt_empty got %b exp 0", empty); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL cmt_count got %0d exp 3", count); end
    checks++; if (r_data !== 8'hA1) begin errors++; $display("FAIL cmt_rdata got %h exp a1", r_data); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (r_data !== m_cmt[0]) begin errors++; $display("FAIL cmt_drain%0d got %h exp %h", i, r_data, m_cmt[0]); end
      cycle(0, 8'h00, 0, 0, 1, 0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL cmt_drained got %b exp 1", empty); end
  endtask

  task automatic test_discard();
    cycle(1, 8'h10, 1, 0, 0, 0);
    cycle(1, 8'h11, 0, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0, 0);
    cycle(1, 8'hFF, 1, 1, 0, 0);
    checks++; if (pkt_len !== 3'd0) begin errors++; $display("FAIL disc_pkt_len got %0d exp 0", pkt_len); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL disc_count got %0d exp 1", count); end
    cycle(1, 8'h33, 1, 0, 0, 0);
    checks++; if (r_data !== 8'h10) begin errors++; $display("FAIL disc_rd0 got %h exp 10", r_data); end
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (r_data !== 8'h33) begin errors++; $display("FAIL disc_rd1 got %h exp 33", r_data); end
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL disc_empty got %b exp 1", empty); end
  endtask

  task automatic test_full();
    logic [NB-1:0] w[4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    for (int i = 0; i < 4; i++) cycle(1, w[i], (i == 3), 0, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    cycle(1, 8'hEE, 1, 0, 0, 0);
    checks++; if ({count, pkt_len} !== {3'd4, 3'd0}) begin errors++; $display("FAIL full_ignore got %0d/%0d exp 4/0", count, pkt_len); end
`ifdef FLEX_PKT_FIFO_ERR_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b exp 1", overflow); end
`endif
    // Read while full does not unblock a same-cycle write.
    cycle(1, 8'hEF, 0, 0, 1, 0);
    checks++; if ({count, pkt_len} !== {3'd3, 3'd0}) begin errors++; $display("FAIL full_rw got %0d/%0d exp 3/0", count, pkt_len); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (r_data !== w[i]) begin errors++; $display("FAIL full_rd%0d got %h exp %h", i, r_data, w[i]); end
      cycle(0, 8'h00, 0, 0, 1, 0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got %b exp 1", empty); end
`ifdef FLEX_PKT_FIFO_ERR_EN
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow got %b exp 1", underflow); end
    cycle(0, 8'h00, 0, 0, 1, 1);
    checks++; if ({overflow, underflow} !== {m_ov, m_un}) begin errors++; $display("FAIL clr_set got %b exp %b", {overflow, underflow}, {m_ov, m_un}); end
    cycle(0, 8'h00, 0, 0, 0, 1);
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL err_clr got %b exp 00", {overflow, underflow}); end
`endif
  endtask

  task automatic test_same_cycle();
    cycle(1, 8'h55, 1, 0, 1, 0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL same_count got %0d exp 1", count); end
    checks++; if (r_data !== 8'h55) begin errors++; $display("FAIL same_rdata got %h exp 55", r_data); end
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL same_empty got %b exp 1", empty); end
  endtask

  task automatic test_stream();
    logic [NB-1:0] sent[$];
    logic [NB-1:0] got[$];
    int n_sent = 0;
    int cyc = 0;
    int bad = 0;
    logic we, wc, re;
    logic [NB-1:0] wd;
    bit mf, me;
    while ((n_sent < 10 * DP || m_cmt.size() > 0 || m_tnt.size() > 0) && cyc < 3000) begin
      mf = (m_cmt.size() + m_tnt.size()) == DP;
      me = (m_cmt.size() == 0);
      we = (n_sent < 10 * DP) && ($urandom_range(0, 3) != 0);
      wd = NB'($urandom);
      re = (n_sent >= 10 * DP) || ($urandom_range(0, 2) != 0);
      wc = 1'b0;
      if (we && !mf) begin
        sent.push_back(wd);
        n_sent++;
        wc = (n_sent % 3 == 0) || (n_sent == 10 * DP);
      end
      if (re && !me) begin
        got.push_back(r_data);
        checks++; if (r_data !== m_cmt[0]) begin errors++; $display("FAIL stream_rdata cyc %0d got %h exp %h", cyc, r_data, m_cmt[0]); end
      end
      cycle(we, wd, wc, 0, re, 0);
      checks++; if (count !== (AW+1)'(m_cmt.size())) begin errors++; $display("FAIL stream_count cyc %0d got %0d exp %0d", cyc, count, m_cmt.size()); end
      checks++; if (pkt_len !== (AW+1)'(m_tnt.size())) begin errors++; $display("FAIL stream_pkt_len cyc %0d got %0d exp %0d", cyc, pkt_len, m_tnt.size()); end
      cyc++;
    end
    checks++; if (cyc >= 3000) begin errors++; $display("FAIL stream_timeout got %0d cycles exp <3000", cyc); end
    checks++; if (got.size() != sent.size()) begin errors++; $display("FAIL stream_len got %0d exp %0d", got.size(), sent.size()); end
    for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_order got %0d out-of-order words exp 0", bad); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 8'h01, 0, 0, 0, 0);
    cycle(1, 8'h02, 1, 0, 0, 0);
    cycle(1, 8'h03, 0, 0, 0, 0);
    checks++; if ({count, pkt_len} !== {3'd2, 3'd1}) begin errors++; $display("FAIL mid_pre got %0d/%0d exp 2/1", count, pkt_len); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if ({empty, full, count, pkt_len} !== {1'b1, 1'b0, 3'd0, 3'd0}) begin errors++; $display("FAIL mid_flags got %b%b %0d/%0d exp 10 0/0", empty, full, count, pkt_len); end
    checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL mid_rdata got %h exp 00", r_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1, 8'h77, 1, 0, 0, 0);
    checks++; if ({count, r_data} !== {3'd1, 8'h77}) begin errors++; $display("FAIL mid_after got %0d/%h exp 1/77", count, r_data); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_discard();
    test_full();
    test_same_cycle();
    test_stream();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
